// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-to-UART streamer: FSM state encoding,
// frame geometry and the baud counter width helper.
`timescale 1ns/1ps
package fifo_uart_pkg;

   // Transmit FSM states, encoded 0..5 in frame order
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_START = 3'd3,
      S_DATA  = 3'd4,
      S_STOP  = 3'd5
   } state_t;

   // 8N1 frame: start + 8 data + stop
   localparam int FRAME_LEN = 10;
   localparam int DATA_BITS = 8;

   // Width of a counter that must hold 0..div-1 (div >= 2)
   function automatic int baud_cnt_w(input int div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer. Counts 0..BAUD_DIV-1 and flags the last cycle of each
// period (tick) and the cycle before it (tick_pre). Holding clear keeps the
// count at zero so a period starts cleanly on the next state entry.
`timescale 1ns/1ps
module baud_tick_gen
   import fifo_uart_pkg::*;
#(
   parameter int BAUD_DIV = 868
) (
   input  logic Clk,
   input  logic Rst_n,
   input  logic clear,
   output logic tick,
   output logic tick_pre
);

   localparam int CW = baud_cnt_w(BAUD_DIV);
   localparam logic [CW-1:0] LAST_C = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] PRE_C  = CW'(BAUD_DIV - 2);

   logic [CW-1:0] cnt_r;

   // Free-running period counter, restarted by clear or at the end of a period
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_r <= '0;
      end else if (clear || (cnt_r == LAST_C)) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   // Period markers decoded straight from the counter register
   assign tick     = (cnt_r == LAST_C);
   assign tick_pre = (cnt_r == PRE_C);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a normal-mode (1-cycle latency) FIFO read port and sends
// each one as an 8N1 UART frame. All outputs are registered.
`timescale 1ns/1ps
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int BAUD_DIV = 868,
   parameter int CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             En,
   input  logic             fifo_rdempty,
   input  logic [7:0]       fifo_q,
   output logic             fifo_rdreq,
   output logic             uart_tx,
   output logic             busy,
   output logic             tx_done,
   output logic [CNT_W-1:0] sent_cnt
);

   state_t     state_r;
   logic [7:0] shift_r;
   logic [2:0] bit_idx_r;
   logic       clear_s;
   logic       tick_s;
   logic       tick_pre_s;

   baud_tick_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .clear    (clear_s),
      .tick     (tick_s),
      .tick_pre (tick_pre_s)
   );

   // Hold the bit timer at zero in the untimed states so START begins a fresh
   // period; timed states hand over exactly at the period wrap.
   always_comb begin
      clear_s = 1'b0;
      case (state_r)
         S_IDLE, S_REQ, S_WAIT: clear_s = 1'b1;
         default:               clear_s = 1'b0;
      endcase
   end

   // Transmit FSM with all outputs registered alongside the state
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_r    <= S_IDLE;
         shift_r    <= 8'h00;
         bit_idx_r  <= 3'd0;
         fifo_rdreq <= 1'b0;
         uart_tx    <= 1'b1;
         busy       <= 1'b0;
         tx_done    <= 1'b0;
         sent_cnt   <= '0;
      end else begin
         fifo_rdreq <= 1'b0;
         tx_done    <= 1'b0;
         case (state_r)
            S_IDLE: begin
               uart_tx <= 1'b1;
               busy    <= 1'b0;
               // The empty flag is only looked at here, so no pop ever hits an empty FIFO
               if (En && !fifo_rdempty) begin
                  state_r    <= S_REQ;
                  fifo_rdreq <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            S_REQ: begin
               state_r <= S_WAIT;
            end
            S_WAIT: begin
               // Read data is valid this cycle; committed to the frame regardless of En
               shift_r <= fifo_q;
               uart_tx <= 1'b0;
               state_r <= S_START;
            end
            S_START: begin
               if (tick_s) begin
                  uart_tx   <= shift_r[0];
                  shift_r   <= {1'b0, shift_r[7:1]};
                  bit_idx_r <= 3'd0;
                  state_r   <= S_DATA;
               end
            end
            S_DATA: begin
               if (tick_s) begin
                  if (bit_idx_r == 3'(DATA_BITS - 1)) begin
                     uart_tx   <= 1'b1;
                     bit_idx_r <= 3'd0;
                     state_r   <= S_STOP;
                  end else begin
                     uart_tx   <= shift_r[0];
                     shift_r   <= {1'b0, shift_r[7:1]};
                     bit_idx_r <= bit_idx_r + 3'd1;
                  end
               end
            end
            S_STOP: begin
               // Raise tx_done one cycle early so it lands on the final stop cycle
               if (tick_pre_s) begin
                  tx_done <= 1'b1;
               end
               if (tick_s) begin
                  sent_cnt <= sent_cnt + CNT_W'(1);
                  busy     <= 1'b0;
                  state_r  <= S_IDLE;
               end
            end
            default: begin
               state_r <= S_IDLE;
               uart_tx <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with BAUD_DIV=4 and a 1-cycle-latency FIFO model.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
   import fifo_uart_pkg::*;

   localparam int BD       = 4;
   localparam int DONE_K   = 1 + FRAME_LEN * BD;      // 41: last stop cycle, REQ cycle is k=0
   localparam int SPACING  = 3 + FRAME_LEN * BD;      // 43

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b1;
   logic        En = 1'b0;
   logic        fifo_rdempty;
   logic [7:0]  fifo_q = 8'h00;
   logic        fifo_rdreq, uart_tx, busy, tx_done;
   logic [15:0] sent_cnt;

   logic        en2 = 1'b0;
   logic        rdempty2 = 1'b1;
   logic [7:0]  q2 = 8'h5A;
   logic        rdreq2, tx2, busy2, done2;
   logic [1:0]  cnt2;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [7:0] mem [0:1023];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int underflow = 0;

   fifo_uart_tx #(.BAUD_DIV(BD), .CNT_W(16)) u_dut (
      .Clk(Clk), .Rst_n(Rst_n), .En(En), .fifo_rdempty(fifo_rdempty),
      .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq), .uart_tx(uart_tx),
      .busy(busy), .tx_done(tx_done), .sent_cnt(sent_cnt));

   fifo_uart_tx #(.BAUD_DIV(BD), .CNT_W(2)) u_wrap (
      .Clk(Clk), .Rst_n(Rst_n), .En(en2), .fifo_rdempty(rdempty2),
      .fifo_q(q2), .fifo_rdreq(rdreq2), .uart_tx(tx2),
      .busy(busy2), .tx_done(done2), .sent_cnt(cnt2));

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // FIFO model: data appears on fifo_q the cycle after rdreq
   always @(posedge Clk) begin
      if (fifo_rdreq) begin
         if (rd_ptr != wr_ptr) begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
         end else begin
            underflow <= underflow + 1;
         end
      end
   end
   assign fifo_rdempty = (rd_ptr == wr_ptr);

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic apply_reset();
      @(negedge Clk);
      Rst_n = 1'b0;
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   task automatic wait_rdreq(input int budget, output int req_cyc, output bit ok);
      int n;
      ok = 1'b0;
      n = 0;
      req_cyc = -1;
      while (!ok && n < budget) begin
         @(negedge Clk);
         n++;
         if (fifo_rdreq) begin
            ok = 1'b1;
            req_cyc = cyc;
         end
      end
   endtask

   // Waits for the pop, then follows the frame cycle by cycle against expv.
   // Ends on the IDLE cycle after the stop bit (k=42).
   task automatic do_frame(input string tag, input logic [9:0] expv, input int drop_k,
                           output int req_cyc);
      bit         ok;
      logic [9:0] obs;
      int         done_k;
      int         bad;
      int         b;
      wait_rdreq(100, req_cyc, ok);
      check_val({tag, ".rdreq_seen"}, 32'(ok), 32'd1);
      if (ok) begin
         obs = 10'h000;
         done_k = -1;
         bad = 0;
         for (int k = 1; k <= DONE_K; k++) begin
            @(negedge Clk);
            if (k == drop_k) En = 1'b0;
            if (fifo_rdreq || !busy) bad++;
            if (tx_done) begin
               if (done_k < 0) done_k = k;
               else bad++;
            end
            if (k == 1) begin
               if (uart_tx !== 1'b1) bad++;
            end else begin
               b = (k - 2) / BD;
               if (uart_tx !== expv[b]) bad++;
               if (((k - 2) % BD) == 2) obs[b] = uart_tx;
            end
         end
         @(negedge Clk);
         if (busy || tx_done || uart_tx !== 1'b1) bad++;
         check_val({tag, ".frame"}, 32'(obs), 32'(expv));
         check_val({tag, ".done_k"}, 32'(done_k), 32'(DONE_K));
         check_val({tag, ".bad_cycles"}, 32'(bad), 32'd0);
      end
   endtask

   initial begin
      int rc, prev_rc, cnt_rq, cnt_line, cnt_busy;
      int vals [0:4];
      int nv, budget, rq2;
      bit pd;

      // ---- Scenario 1: reset values and idle with empty FIFO ----
      #2 Rst_n = 1'b0;
      #1;
      check_val("rst.uart_tx", 32'(uart_tx), 32'd1);
      check_val("rst.rdreq", 32'(fifo_rdreq), 32'd0);
      check_val("rst.busy", 32'(busy), 32'd0);
      check_val("rst.tx_done", 32'(tx_done), 32'd0);
      check_val("rst.sent_cnt", 32'(sent_cnt), 32'd0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      En = 1'b1;
      cnt_rq = 0; cnt_line = 0; cnt_busy = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge Clk);
         if (fifo_rdreq) cnt_rq++;
         if (uart_tx !== 1'b1) cnt_line++;
         if (busy) cnt_busy++;
      end
      check_val("empty.rdreq_count", 32'(cnt_rq), 32'd0);
      check_val("empty.line_low", 32'(cnt_line), 32'd0);
      check_val("empty.busy_count", 32'(cnt_busy), 32'd0);
      check_val("empty.sent_cnt", 32'(sent_cnt), 32'd0);

      // ---- Scenario 2: single byte 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 ----
      load(8'hA5);
      do_frame("a5", 10'h34A, -1, rc);
      check_val("a5.sent_cnt", 32'(sent_cnt), 32'd1);

      // ---- Scenario 3: 512 bytes streamed back to back ----
      En = 1'b0;
      apply_reset();
      for (int i = 0; i < 512; i++) load(8'(i));
      En = 1'b1;
      prev_rc = 0;
      for (int i = 0; i < 512; i++) begin
         logic [7:0] d;
         d = 8'(i);
         do_frame($sformatf("stream%0d", i), {1'b1, d, 1'b0}, -1, rc);
         if (i > 0) check_val($sformatf("stream%0d.spacing", i), 32'(rc - prev_rc), 32'(SPACING));
         prev_rc = rc;
      end
      check_val("stream.rdempty", 32'(fifo_rdempty), 32'd1);
      check_val("stream.sent_cnt", 32'(sent_cnt), 32'd512);

      // ---- Scenario 4: drop En during data bit 3 of 0x3C ----
      load(8'h3C);
      load(8'h81);
      do_frame("en_drop", {1'b1, 8'h3C, 1'b0}, 2 + 4 * BD + 1, rc);
      cnt_rq = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge Clk);
         if (fifo_rdreq) cnt_rq++;
      end
      check_val("en_low.rdreq_count", 32'(cnt_rq), 32'd0);
      check_val("en_low.rdempty", 32'(fifo_rdempty), 32'd0);
      check_val("en_low.sent_cnt", 32'(sent_cnt), 32'd513);
      En = 1'b1;
      do_frame("en_resume", {1'b1, 8'h81, 1'b0}, -1, rc);
      check_val("en_resume.sent_cnt", 32'(sent_cnt), 32'd514);

      // ---- Scenario 5: async reset during DATA of 0x77 ----
      load(8'h77);
      load(8'h12);
      wait_rdreq(100, rc, pd);
      check_val("rst_mid.rdreq_seen", 32'(pd), 32'd1);
      repeat (2 + 4 * BD + 2) @(negedge Clk);  // mid data bit 3 (0 for 0x77)
      check_val("rst_mid.line_before", 32'(uart_tx), 32'd0);
      #1 Rst_n = 1'b0;
      #1;
      check_val("rst_mid.uart_tx", 32'(uart_tx), 32'd1);
      check_val("rst_mid.busy", 32'(busy), 32'd0);
      check_val("rst_mid.sent_cnt", 32'(sent_cnt), 32'd0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      do_frame("rst_next", {1'b1, 8'h12, 1'b0}, -1, rc);
      check_val("rst_next.sent_cnt", 32'(sent_cnt), 32'd1);

      // ---- Scenario 6: counter wrap on a 2-bit sent_cnt instance ----
      rdempty2 = 1'b0;
      en2 = 1'b1;
      nv = 0; budget = 0; rq2 = 0; pd = 1'b0;
      while (nv < 5 && budget < 5 * SPACING + 50) begin
         @(negedge Clk);
         budget++;
         if (rdreq2) rq2++;
         if (pd) begin
            vals[nv] = int'(cnt2);
            nv++;
         end
         pd = done2;
      end
      en2 = 1'b0;
      check_val("wrap.pulses", 32'(nv), 32'd5);
      check_val("wrap.cnt_after3", 32'(vals[2]), 32'd3);
      check_val("wrap.cnt_after4", 32'(vals[3]), 32'd0);
      check_val("wrap.cnt_after5", 32'(vals[4]), 32'd1);
      check_val("wrap.rdreq_count", 32'(rq2), 32'd5);
      check_val("wrap.idle_busy", 32'(busy2), 32'd0);
      check_val("wrap.idle_line", 32'(tx2), 32'd1);

      check_val("fifo.underflow", 32'(underflow), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
